pipelined_cla_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with a pipeline register after every GROUPS_PER_STAGE groups.
- Carry ripples between stages; unprocessed upper operand bits and finished lower sum bits travel with it.
- Valid/ready handshake on both sides and a global stall.
- Successor to the team's fixed 4-bit combinational lookahead adder, for wide datapaths at higher clock rates.

---
 rtl/pipelined_cla_addsub.sv | 132 +++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: add/sub built from 4-bit lookahead groups with a
// pipeline register after every GROUPS_PER_STAGE groups.
//
// Parameters: WIDTH (multiple of 4), GROUPS_PER_STAGE (>= 1).
// Latency is ceil((WIDTH/4)/GROUPS_PER_STAGE) registers.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, x, y, cin, sub
// on the input side; out_valid/out_ready, sum, cout, ovf, zero on the output.
// Define PIPELINED_CLA_SAT_EN to saturate sum on signed overflow.
module pipelined_cla_addsub #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGROUPS = WIDTH / 4;
  localparam int LATENCY =
    (NGROUPS + GROUPS_PER_STAGE - 1) / GROUPS_PER_STAGE;
  localparam int LAST = LATENCY - 1;
  localparam int MSB = WIDTH - 1;

  // x/y keep the upper operand bits still to be added (and the MSBs
  // the overflow check needs); s collects finished low sum bits.
  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] s;
  } stg_t;

  function automatic logic [4:0] cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       c
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;
    g = a & b;
    p = a ^ b;
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & c);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]) | (&p & c);
    return {cc[4], p ^ cc[3:0]};
  endfunction

  logic             advance;
  stg_t             head;
  stg_t             s_in [LATENCY];
  stg_t             d    [LATENCY];
  stg_t             q    [LATENCY];
  logic             ovf_d;
  logic             zero_d;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] sum_d;

  assign advance = !q[LAST].v | out_ready;
  assign in_ready = advance;

  // Subtraction is x + ~y + 1, so cin is overridden by sub.
  assign head = {in_valid, sub | cin, x,
                 sub ? ~y : y, {WIDTH{1'b0}}};

  always_comb begin
    logic       cy;
    logic [4:0] r;
    s_in[0] = head;
    for (int k = 1; k < LATENCY; k++) s_in[k] = q[k-1];
    for (int k = 0; k < LATENCY; k++) begin
      d[k] = s_in[k];
      cy = s_in[k].c;
      for (int j = 0; j < NGROUPS; j++) begin
        if (j / GROUPS_PER_STAGE == k) begin
          r = cla4(s_in[k].x[4*j +: 4], s_in[k].y[4*j +: 4], cy);
          d[k].s[4*j +: 4] = r[3:0];
          cy = r[4];
        end
      end
      d[k].c = cy;
    end
    // Carry into the MSB is recovered as x^y^s at that bit.
    ovf_d = d[LAST].x[MSB] ^ d[LAST].y[MSB]
          ^ d[LAST].s[MSB] ^ d[LAST].c;
    sum_d = d[LAST].s;
`ifdef PIPELINED_CLA_SAT_EN
    if (ovf_d) begin
      sum_d = d[LAST].x[MSB] ? {1'b1, {MSB{1'b0}}}
                             : {1'b0, {MSB{1'b1}}};
    end
`endif
    zero_d = ~|sum_d;
    d[LAST].s = sum_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) q[k] <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < LATENCY; k++) q[k] <= d[k];
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = q[LAST].v;
  assign sum       = q[LAST].s;
  assign cout      = q[LAST].c;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: scoreboard bench for the pipelined adder,
// one 16-bit/GPS=1 instance plus 32-bit GPS=3 and GPS=8 instances.
module tb_pipelined_cla_addsub;

  localparam int AW = 16;
  localparam int AL = 4;
  localparam int BW = 32;

  typedef logic [66:0] res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_iv, a_ir, a_cin, a_sub, a_ov, a_or;
  logic          a_cout, a_ovf, a_zero;
  logic [AW-1:0] a_x, a_y, a_sum;
  logic          b_iv, b_ir, b_cin, b_sub, b_ov, b_or;
  logic          b_cout, b_ovf, b_zero;
  logic [BW-1:0] b_x, b_y, b_sum;
  logic          c_iv, c_ir, c_cin, c_sub, c_ov, c_or;
  logic          c_cout, c_ovf, c_zero;
  logic [BW-1:0] c_x, c_y, c_sum;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t qa[$];
  res_t qb[$];
  res_t qc[$];
  int   pa = 0, pb = 0, pc = 0;
  int   ra = 0;

  pipelined_cla_addsub #(.WIDTH(AW), .GROUPS_PER_STAGE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .x(a_x), .y(a_y), .cin(a_cin), .sub(a_sub),
    .out_valid(a_ov), .out_ready(a_or), .sum(a_sum),
    .cout(a_cout), .ovf(a_ovf), .zero(a_zero));

  pipelined_cla_addsub #(.WIDTH(BW), .GROUPS_PER_STAGE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .x(b_x), .y(b_y), .cin(b_cin), .sub(b_sub),
    .out_valid(b_ov), .out_ready(b_or), .sum(b_sum),
    .cout(b_cout), .ovf(b_ovf), .zero(b_zero));

  pipelined_cla_addsub #(.WIDTH(BW), .GROUPS_PER_STAGE(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
    .x(c_x), .y(c_y), .cin(c_cin), .sub(c_sub),
    .out_valid(c_ov), .out_ready(c_or), .sum(c_sum),
    .cout(c_cout), .ovf(c_ovf), .zero(c_zero));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition, {zero, ovf, cout, sum[63:0]}.
  function automatic res_t model(input int w, input logic [63:0] x,
                                 input logic [63:0] y,
                                 input logic ci, input logic sb);
    logic [64:0] full;
    logic [63:0] mask, ye, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    ye   = sb ? (~y & mask) : (y & mask);
    full = {1'b0, x & mask} + {1'b0, ye} + {64'd0, sb | ci};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (x[w-1] == ye[w-1]) && (s[w-1] != x[w-1]);
`ifdef PIPELINED_CLA_SAT_EN
    if (ov) s = x[w-1] ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`endif
    return {s == 64'd0, ov, co, s};
  endfunction

  function automatic logic [63:0] rv(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return mask;
      1: return 64'd0;
      2: return 64'd1 << (w-1);
      3: return (64'd1 << (w-1)) - 64'd1;
      default: return {32'($urandom), 32'($urandom)} & mask;
    endcase
  endfunction

  always @(negedge clk) begin : mon_a
    res_t e;
    if (rst_n) begin
      if (a_ov && a_or) begin
        if (qa.size() == 0) chk("a_unexpected", 64'(a_ov), 64'd0);
        else begin
          e = qa.pop_front();
          ra++;
          chk("a_sum", 64'(a_sum), e[63:0]);
          chk("a_cout", 64'(a_cout), 64'(e[64]));
          chk("a_ovf", 64'(a_ovf), 64'(e[65]));
          chk("a_zero", 64'(a_zero), 64'(e[66]));
        end
      end
      if (a_iv && a_ir) begin
        qa.push_back(model(AW, 64'(a_x), 64'(a_y), a_cin, a_sub));
        pa++;
      end
    end
  end

  always @(negedge clk) begin : mon_b
    res_t e;
    if (rst_n) begin
      if (b_ov && b_or) begin
        if (qb.size() == 0) chk("b_unexpected", 64'(b_ov), 64'd0);
        else begin
          e = qb.pop_front();
          chk("b_sum", 64'(b_sum), e[63:0]);
          chk("b_cout", 64'(b_cout), 64'(e[64]));
          chk("b_ovf", 64'(b_ovf), 64'(e[65]));
          chk("b_zero", 64'(b_zero), 64'(e[66]));
        end
      end
      if (b_iv && b_ir) begin
        qb.push_back(model(BW, 64'(b_x), 64'(b_y), b_cin, b_sub));
        pb++;
      end
    end
  end

  always @(negedge clk) begin : mon_c
    res_t e;
    if (rst_n) begin
      if (c_ov && c_or) begin
        if (qc.size() == 0) chk("c_unexpected", 64'(c_ov), 64'd0);
        else begin
          e = qc.pop_front();
          chk("c_sum", 64'(c_sum), e[63:0]);
          chk("c_cout", 64'(c_cout), 64'(e[64]));
          chk("c_ovf", 64'(c_ovf), 64'(e[65]));
          chk("c_zero", 64'(c_zero), 64'(e[66]));
        end
      end
      if (c_iv && c_ir) begin
        qc.push_back(model(BW, 64'(c_x), 64'(c_y), c_cin, c_sub));
        pc++;
      end
    end
  end

  task automatic send_a(input logic [AW-1:0] x, input logic [AW-1:0] y,
                        input logic ci, input logic sb);
    int t;
    a_x = x; a_y = y; a_cin = ci; a_sub = sb; a_iv = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!a_ir && t < 50);
    if (!a_ir) chk("a_accept_timeout", 64'(a_ir), 64'd1);
    @(posedge clk);
    #1;
    a_iv = 1'b0;
  endtask

  task automatic drain_a();
    int t;
    t = 0;
    while (qa.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("a_drain", 64'(qa.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Send one beat into an idle pipe and check the exact latency.
  task automatic run1(input string tag, input logic [AW-1:0] x,
                      input logic [AW-1:0] y, input logic ci,
                      input logic sb, input logic [AW-1:0] es,
                      input logic ec, input logic eo, input logic ez);
    send_a(x, y, ci, sb);
    for (int i = 0; i < AL - 1; i++) begin
      chk({tag, "_early"}, 64'(a_ov), 64'd0);
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, 64'(a_ov), 64'd1);
    chk({tag, "_sum"}, 64'(a_sum), 64'(es));
    chk({tag, "_cout"}, 64'(a_cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(a_ovf), 64'(eo));
    chk({tag, "_zero"}, 64'(a_zero), 64'(ez));
    drain_a();
  endtask

  task automatic rand_a(input int n);
    int p0, t;
    p0 = pa;
    t = 0;
    while (pa - p0 < n && t < 20000) begin
      @(posedge clk);
      #1;
      a_iv = $urandom_range(0, 9) < 7;
      a_or = $urandom_range(0, 9) < 7;
      a_x = AW'(rv(AW));
      a_y = AW'(rv(AW));
      a_cin = 1'($urandom_range(0, 1));
      a_sub = 1'($urandom_range(0, 1));
      t++;
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    chk("a_rand_beats", 64'(pa - p0), 64'(n));
    drain_a();
  endtask

  task automatic rand_b(input int n);
    int p0, t;
    p0 = pb;
    t = 0;
    while (pb - p0 < n && t < 20000) begin
      @(posedge clk);
      #1;
      b_iv = $urandom_range(0, 9) < 7;
      b_or = $urandom_range(0, 9) < 7;
      b_x = BW'(rv(BW));
      b_y = BW'(rv(BW));
      b_cin = 1'($urandom_range(0, 1));
      b_sub = 1'($urandom_range(0, 1));
      t++;
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    chk("b_rand_beats", 64'(pb - p0), 64'(n));
    t = 0;
    while (qb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("b_drain", 64'(qb.size()), 64'd0);
  endtask

  task automatic rand_c(input int n);
    int p0, t;
    p0 = pc;
    t = 0;
    while (pc - p0 < n && t < 20000) begin
      @(posedge clk);
      #1;
      c_iv = $urandom_range(0, 9) < 7;
      c_or = $urandom_range(0, 9) < 7;
      c_x = BW'(rv(BW));
      c_y = BW'(rv(BW));
      c_cin = 1'($urandom_range(0, 1));
      c_sub = 1'($urandom_range(0, 1));
      t++;
    end
    c_iv = 1'b0;
    c_or = 1'b1;
    chk("c_rand_beats", 64'(pc - p0), 64'(n));
    t = 0;
    while (qc.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("c_drain", 64'(qc.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    a_iv = 0; a_or = 1; a_x = '0; a_y = '0; a_cin = 0; a_sub = 0;
    b_iv = 0; b_or = 1; b_x = '0; b_y = '0; b_cin = 0; b_sub = 0;
    c_iv = 0; c_or = 1; c_x = '0; c_y = '0; c_cin = 0; c_sub = 0;
    #12;
    chk("rst_valid", 64'(a_ov), 64'd0);
    chk("rst_sum", 64'(a_sum), 64'd0);
    chk("rst_cout", 64'(a_cout), 64'd0);
    chk("rst_ovf", 64'(a_ovf), 64'd0);
    chk("rst_zero", 64'(a_zero), 64'd0);
    chk("rst_in_ready", 64'(a_ir), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run1("basic", 16'h1234, 16'h4321, 1'b0, 1'b0,
         16'h5555, 1'b0, 1'b0, 1'b0);
    run1("chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0,
         16'h0000, 1'b1, 1'b0, 1'b1);
    run1("sub", 16'h0005, 16'h0007, 1'b0, 1'b1,
         16'hFFFE, 1'b0, 1'b0, 1'b0);
    run1("sub_cin", 16'h0010, 16'h0010, 1'b1, 1'b1,
         16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef PIPELINED_CLA_SAT_EN
    run1("neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1,
         16'h8000, 1'b1, 1'b1, 1'b0);
    run1("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
         16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
    run1("neg_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1,
         16'h7FFF, 1'b1, 1'b1, 1'b0);
    run1("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
         16'h8000, 1'b0, 1'b1, 1'b0);
`endif

    r0 = ra;
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send_a(AW'(i), AW'(i), 1'b0, 1'b0);
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!a_ov && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("stall_wait", 64'(a_ov), 64'd1);
        @(posedge clk);
        #1;
        a_or = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(a_ir), 64'd0);
          chk("stall_valid", 64'(a_ov), 64'd1);
          chk("stall_sum", 64'(a_sum), 64'd4);
        end
        @(posedge clk);
        #1;
        a_or = 1'b1;
      end
    join
    drain_a();
    chk("stall_count", 64'(ra - r0), 64'd6);

    for (int i = 0; i < 4; i++)
      send_a(AW'(16'h0100 + i), 16'h0011, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(a_ov), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(a_ov), 64'd0);
    chk("mid_rst_sum", 64'(a_sum), 64'd0);
    chk("mid_rst_cout", 64'(a_cout), 64'd0);
    chk("mid_rst_ovf", 64'(a_ovf), 64'd0);
    chk("mid_rst_zero", 64'(a_zero), 64'd0);
    chk("mid_rst_in_ready", 64'(a_ir), 64'd1);
    qa.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run1("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0,
         16'h0002, 1'b0, 1'b0, 1'b0);

    fork
      rand_a(1000);
      rand_b(1000);
      rand_c(1000);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
